// File: rtl/fp_regfile_sb.sv
// fp_regfile_sb: floating-point register file with an integrated busy
// scoreboard, write-to-read bypass and fcsr (frm + sticky fflags) state.
// Read ports are combinational. Writeback data bypasses to a read of the same
// register in the same cycle, and that bypass also hides the register's busy bit.
// Optional build macro FRF_NANBOX_EN (effective only with FLEN=64) enables
// NaN-boxing of single-precision writes and checking of single-precision reads.
module fp_regfile_sb #(
    parameter int FLEN       = 32,
    parameter int NUM_REGS   = 32,
    parameter int NUM_RPORTS = 3,
    localparam int AW        = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NUM_RPORTS*AW-1:0]   raddr,
    output logic [NUM_RPORTS*FLEN-1:0] rdata,
    output logic [NUM_RPORTS-1:0]      rbusy,
    input  logic                       wen,
    input  logic [AW-1:0]              waddr,
    input  logic [FLEN-1:0]            wdata,
    input  logic                       wsingle,
    input  logic [NUM_RPORTS-1:0]      rsingle,
    input  logic                       issue_valid,
    input  logic [AW-1:0]              issue_rd,
    output logic [NUM_REGS-1:0]        busy,
    input  logic                       flags_valid,
    input  logic [4:0]                 flags_in,
    input  logic                       csr_wen,
    input  logic [1:0]                 csr_sel,
    input  logic [7:0]                 csr_wdata,
    output logic [7:0]                 csr_rdata,
    output logic [2:0]                 frm
);

    localparam logic [1:0] SEL_NONE   = 2'b00;
    localparam logic [1:0] SEL_FFLAGS = 2'b01;
    localparam logic [1:0] SEL_FRM    = 2'b10;
    localparam logic [1:0] SEL_FCSR   = 2'b11;

    logic [FLEN-1:0]     regs_r [NUM_REGS];
    logic [NUM_REGS-1:0] busy_r;
    logic [4:0]          fflags_r;
    logic [2:0]          frm_r;

    logic [FLEN-1:0]     wdata_eff_s;
    logic                wen_ok_s;
    logic                issue_ok_s;
    logic                csr_fflags_wr_s;
    logic                unused_s;

    // Addresses at or above NUM_REGS do not name a register.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (32'(a) < 32'(NUM_REGS));
    endfunction

    assign wen_ok_s        = wen && in_range(waddr);
    assign issue_ok_s      = issue_valid && in_range(issue_rd);
    assign csr_fflags_wr_s = csr_wen && ((csr_sel == SEL_FFLAGS) || (csr_sel == SEL_FCSR));

    // The precision hints are consumed only in the NaN-boxing build.
    assign unused_s = ^{wsingle, rsingle};

`ifdef FRF_NANBOX_EN
    if (FLEN == 64) begin : g_nanbox_w
        // Single-precision writeback is NaN-boxed before storage and bypass.
        always_comb begin
            if (wsingle) begin
                wdata_eff_s = {32'hFFFF_FFFF, wdata[31:0]};
            end else begin
                wdata_eff_s = wdata;
            end
        end
    end else begin : g_plain_w
        assign wdata_eff_s = wdata;
    end
`else
    assign wdata_eff_s = wdata;
`endif

    // Register array: reset to zero, written on writeback.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                regs_r[r] <= {FLEN{1'b0}};
            end
        end else if (wen_ok_s) begin
            regs_r[waddr] <= wdata_eff_s;
        end
    end

    // Scoreboard: writeback clears, issue sets; issue is applied last so it wins.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            busy_r <= {NUM_REGS{1'b0}};
        end else begin
            if (wen_ok_s) begin
                busy_r[waddr] <= 1'b0;
            end
            if (issue_ok_s) begin
                busy_r[issue_rd] <= 1'b1;
            end
        end
    end

    // Sticky exception flags; a CSR write replaces them but same-cycle flags still accrue.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            fflags_r <= 5'b00000;
        end else if (csr_fflags_wr_s) begin
            fflags_r <= csr_wdata[4:0] | (flags_valid ? flags_in : 5'b00000);
        end else if (flags_valid) begin
            fflags_r <= fflags_r | flags_in;
        end
    end

    // Rounding mode: written through the frm view or the upper bits of fcsr.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            frm_r <= 3'b000;
        end else if (csr_wen && (csr_sel == SEL_FRM)) begin
            frm_r <= csr_wdata[2:0];
        end else if (csr_wen && (csr_sel == SEL_FCSR)) begin
            frm_r <= csr_wdata[7:5];
        end
    end

    // CSR read view reflects the state before any write in this cycle.
    always_comb begin
        case (csr_sel)
            SEL_NONE:   csr_rdata = 8'h00;
            SEL_FFLAGS: csr_rdata = {3'b000, fflags_r};
            SEL_FRM:    csr_rdata = {5'b00000, frm_r};
            SEL_FCSR:   csr_rdata = {frm_r, fflags_r};
            default:    csr_rdata = 8'h00;
        endcase
    end

    assign busy = busy_r;
    assign frm  = frm_r;

    for (genvar i = 0; i < NUM_RPORTS; i++) begin : g_rport
        logic [AW-1:0]   ra_s;
        logic            ok_s;
        logic            hit_s;
        logic [FLEN-1:0] raw_s;
        logic [FLEN-1:0] rd_s;

        assign ra_s  = raddr[i*AW +: AW];
        assign ok_s  = in_range(ra_s);
        assign hit_s = wen_ok_s && (waddr == ra_s);

        // Architectural value with same-cycle writeback bypass; out-of-range reads 0.
        always_comb begin
            if (!ok_s) begin
                raw_s = {FLEN{1'b0}};
            end else if (hit_s) begin
                raw_s = wdata_eff_s;
            end else begin
                raw_s = regs_r[ra_s];
            end
        end

`ifdef FRF_NANBOX_EN
        if (FLEN == 64) begin : g_nanbox_r
            // Single-precision reads of an improperly boxed value yield the canonical NaN.
            always_comb begin
                if (rsingle[i] && ok_s) begin
                    if (raw_s[63:32] == 32'hFFFF_FFFF) begin
                        rd_s = {32'hFFFF_FFFF, raw_s[31:0]};
                    end else begin
                        rd_s = {32'hFFFF_FFFF, 32'h7FC0_0000};
                    end
                end else begin
                    rd_s = raw_s;
                end
            end
        end else begin : g_plain_r
            assign rd_s = raw_s;
        end
`else
        assign rd_s = raw_s;
`endif

        assign rdata[i*FLEN +: FLEN] = rd_s;
        assign rbusy[i] = ok_s ? (busy_r[ra_s] & ~hit_s) : 1'b0;
    end

endmodule

// File: doc/fp_regfile_sb.md
Name: fp_regfile_sb

Overview:
Parametrised floating-point register file for the FPU: configurable register width, depth and read-port count (3 ports for fused multiply-add rs3).
- Integrated per-register busy scoreboard for multi-cycle FPU ops.
- Write-to-read bypass.
- fcsr state: frm plus sticky accumulated fflags, with a CSR read/write port.
- Sits between decode/issue, FPU writeback and the CSR unit.

Parameters:
FLEN, 32, register data width (32 or 64)
NUM_REGS, 32, number of FP registers; AW = $clog2(NUM_REGS)
NUM_RPORTS, 3, number of combinational read ports

Ports:
CLK  in  1  clock
nRST  in  1  reset, asynchronous, active-low
raddr  in  NUM_RPORTS*AW  read addresses, port i at [i*AW +: AW]
rdata  out  NUM_RPORTS*FLEN  read data, port i at [i*FLEN +: FLEN]
rbusy  out  NUM_RPORTS  scoreboard busy bit of each read address
wen  in  1  writeback enable
waddr  in  AW  writeback register
wdata  in  FLEN  writeback data
wsingle  in  1  write is single precision (used only with FRF_NANBOX_EN)
rsingle  in  NUM_RPORTS  read is single precision (used only with FRF_NANBOX_EN)
issue_valid  in  1  multi-cycle op issued
issue_rd  in  AW  destination register of the issued op
busy  out  NUM_REGS  full scoreboard vector
flags_valid  in  1  retiring op reports exception flags
flags_in  in  5  {NV,DZ,OF,UF,NX}
csr_wen  in  1  CSR write strobe
csr_sel  in  2  01=fflags, 10=frm, 11=fcsr, 00=none
csr_wdata  in  8  CSR write data, right-aligned
csr_rdata  out  8  selected CSR value, zero-extended, combinational
frm  out  3  current rounding mode

Behaviour:
- Reset (async): all registers, busy, fflags and frm = 0.
  - Hence rdata = 0, rbusy = 0, csr_rdata = 0, frm = 0.
- f0 is an ordinary writable register (not hardwired).
- Write:
  - On a CLK edge with wen=1, reg[waddr] <= wdata.
  - Addresses >= NUM_REGS are ignored.
- Read:
  - Combinational. rdata[i] = reg[raddr[i]].
  - Bypass: if wen && waddr == raddr[i], rdata[i] = wdata in the same cycle.
  - Out-of-range raddr returns 0.
- Scoreboard:
  - issue_valid sets busy[issue_rd] at the edge.
  - wen clears busy[waddr] at the edge.
  - Same-cycle issue_valid and wen to the same register: busy ends at 1 (issue wins).
  - Issue to an already-busy register: busy stays 1, no error.
  - rbusy[i] = busy[raddr[i]] & ~(wen && waddr == raddr[i]) (bypass also hides busy).
- fflags (5 bits, sticky):
  - flags_valid ORs flags_in into fflags each cycle.
  - A CSR write to fflags or fcsr replaces fflags. Same cycle as flags_valid: fflags <= csr_wdata[4:0] | flags_in.
- frm (3 bits): written by csr_sel=10 (csr_wdata[2:0]) or csr_sel=11 (csr_wdata[7:5]). Not affected by flags_valid.
- csr_rdata:
  - fflags → {3'b0, fflags}
  - frm → {5'b0, frm}
  - fcsr → {frm, fflags}
  - 00 → 0
  - Returns pre-write value in the cycle of a CSR write.
- csr_wen with csr_sel=00: no effect.
- All state updates occur in one cycle. No multi-cycle internal FSM; latency from write to architectural read is 1 edge, 0 with bypass.

Optional Feature:
FRF_NANBOX_EN, only meaningful when FLEN=64.
- Defined:
  - wen with wsingle=1 stores {32'hFFFF_FFFF, wdata[31:0]}; this value also applies to bypass.
  - Read with rsingle[i]=1: returns {32'hFFFF_FFFF, reg[31:0]} if the upper 32 bits are all ones. Otherwise returns {32'hFFFF_FFFF, 32'h7FC0_0000} (canonical NaN).
- Undefined: wsingle/rsingle ignored; data stored and read unmodified.
- With FLEN=32 the macro has no effect.

Test Plan:
1. Reset mid-operation: write f5=0x3F800000, set busy[5], fflags=0x1F, assert nRST=0 asynchronously between edges → rdata, busy, fflags and frm are 0 immediately.
2. Write f0=0x40490FDB; read f0 on all 3 ports next cycle → 0x40490FDB on each. Same-cycle wen f7=0x12345678 with raddr[2]=7 → rdata[2]=0x12345678 before the edge.
3. Scoreboard: issue rd=3 → busy[3]=1. Same cycle issue rd=3 and wen waddr=3 → busy[3] stays 1. Later wen waddr=3 alone → busy[3]=0.
4. Flags: flags_valid with 0x01, then 0x10 → fflags=0x11. csr_wen fcsr=0xA0 with flags_valid 0x04 in the same cycle → frm=3'b101, fflags=0x04, csr_rdata(fcsr)=0xA4.
5. CSR frm write 0x02 → frm=2, fflags unchanged. csr_sel=00 write → no change.
6. FRF_NANBOX_EN, FLEN=64:
   - wsingle write 0x3F800000 → single read = 0xFFFFFFFF3F800000.
   - Double write 0x400921FB54442D18, then single read → 0xFFFFFFFF7FC00000.
